// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC and runs the instruction-memory req/ack handshake.
// It holds the fetched word for the decoder and computes the next PC on retire.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | out of reset, no request outstanding; raises imem_req next cycle
// FETCH | imem_req held high at pc, waiting for imem_ack
// VALID | instr/op_code/funct held for the core, waiting for instr_ready
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instr,
    output logic [5:0]  op_code,
    output logic [5:0]  funct,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retire_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state;
    logic [31:0] branch_off;
    logic [31:0] next_pc;

    assign imem_addr  = pc;
    assign pc_plus4   = pc + 32'd4;
    assign op_code    = instr[31:26];
    assign funct      = instr[5:0];
    assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

    // Jump outranks branch; every target keeps bits [1:0] at zero.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch && zero) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= RESET_PC_ALIGNED;
            imem_req     <= 1'b0;
            instr_valid  <= 1'b0;
            instr        <= 32'd0;
            retire_count <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    imem_req <= 1'b1;
                    state    <= FETCH;
                end
                FETCH: begin
                    if (imem_req && imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= VALID;
                    end
                end
                VALID: begin
                    if (instr_ready) begin
                        pc           <= next_pc;
                        instr_valid  <= 1'b0;
                        imem_req     <= 1'b1;
                        retire_count <= retire_count + 32'd1;
                        state        <= FETCH;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
